magnitude_comparator: RTL and testbench
=======================================

Name: magnitude_comparator

Overview:
- Compares two unsigned WIDTH-bit operands a and b.
- Produces three mutually exclusive, one-hot flags: a_gt_b, a_eq_b, a_lt_b.
- Outputs are registered: one clock of latency, synchronous active-high reset.
- Used as a standalone compare stage in datapaths. Also cascadable, in the 74x85 style, through cascade inputs for wider compares.

Parameters:
- WIDTH, 4, operand width in bits (legal 1..64).
- SIGNED_CMP, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  qualifies a/b/cascade inputs this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- casc_gt  input  1  cascade from less-significant stage: lower bits A>B.
- casc_eq  input  1  cascade: lower bits equal. Tie to 1 when unused.
- casc_lt  input  1  cascade: lower bits A<B.
- out_valid  output  1  registered in_valid.
- a_gt_b  output  1  A greater than B.
- a_eq_b  output  1  A equal to B.
- a_lt_b  output  1  A less than B.

Behaviour:
- All outputs are flops updated on the rising edge of clk. Latency is exactly 1 cycle from in_valid/a/b to out_valid/flags.
- Reset: when rst=1 at a clock edge, out_valid=0, a_gt_b=0, a_eq_b=1, a_lt_b=0. Reset has priority over in_valid. Reset mid-stream drops the in-flight result; no result is produced for that cycle.
- in_valid=0 at a clock edge: out_valid<=0 and the flags hold their previous values.
- in_valid=1 at a clock edge: out_valid<=1 and the flags load the compare result.
- Compare rule, applied in order:
  - a != b: gt = (a>b), lt = (a<b), eq = 0. Cascade inputs are ignored.
  - a == b: the result is taken from the cascade inputs:
    - casc_gt=1 -> gt.
    - else casc_lt=1 -> lt.
    - else casc_eq=1 -> eq.
    - all cascade inputs 0 -> eq (defined fallback).
  - Illegal cascade combos (more than one high) resolve by priority gt > lt > eq.
- Exactly one of a_gt_b/a_eq_b/a_lt_b is 1 after reset and at every clock edge thereafter. Checkers assert this.
- SIGNED_CMP=1: operands are interpreted as two's complement, so the MSB is the sign (e.g. 4'b1000 = -8 < 4'b0000). SIGNED_CMP=0: pure unsigned.
- Combinational path: an MSB-first scan or subtract-based compare. It must close timing for WIDTH=64 in one cycle at the target clock.
- X handling is not required. Inputs are assumed driven whenever in_valid=1 (spec requirement on the integrator).

Decomposition:
- Shared package mag_cmp_pkg:
  - Result encoding constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, packed as {gt,eq,lt}.
  - Default WIDTH constant.
  - A helper function returning the packed result from the gt/lt booleans.
- One sub-module: mag_cmp_core. Purely combinational WIDTH-bit compare of a and b plus cascade resolution, returning {gt,eq,lt}.
- The top level adds the valid pipeline and the output registers only.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 and a=9, b=2 -> out_valid=0, flags {gt,eq,lt}=010 throughout. Deassert -> the first result appears one cycle after the first valid input.
- Unsigned directed set, WIDTH=4, cascade tied 0/1/0, one vector per cycle with in_valid=1. Expected {gt,eq,lt} one cycle later:
  - (0,0)->010
  - (9,2)->100
  - (0,8)->001
  - (4,12)->001
  - (12,11)->100
  - (6,8)->001
  - (5,2)->100
  - (5,15)->001
- Hold: in_valid=1 with a=12, b=11, then in_valid=0 for 3 cycles with a/b changing -> flags stay 100, out_valid drops to 0 after 1 cycle.
- Cascade: a=b=7 with cascade (1,0,0) -> 100; (0,0,1) -> 001; (0,1,0) -> 010; (0,0,0) -> 010; (1,1,1) -> 100. Check a=8, b=7 with cascade (0,0,1) -> 100 (cascade ignored).
- Signed, SIGNED_CMP=1, WIDTH=4: (4'b1000, 4'b0000) -> 001; (4'b1111, 4'b1110) -> 100; (4'b0111, 4'b1000) -> 100.
- Random: 10k random a/b/in_valid/cascade vectors, with rst pulses on 1% of cycles, against a behavioural reference model. The one-hot assertion holds every cycle.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// mag_cmp_pkg: shared definitions for the magnitude comparator.
//   - Result encoding, packed as {gt, eq, lt}.
//   - Default operand width.
//   - pack_result(): builds the packed result from gt/lt booleans.
package mag_cmp_pkg;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT = 3'b100;
    localparam cmp_res_t CMP_EQ = 3'b010;
    localparam cmp_res_t CMP_LT = 3'b001;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // gt wins over lt so the result is always one-hot even if both are set.
    function automatic cmp_res_t pack_result(input logic gt, input logic lt);
        if (gt) begin
            return CMP_GT;
        end else if (lt) begin
            return CMP_LT;
        end
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/mag_cmp_core.sv
// mag_cmp_core: purely combinational WIDTH-bit magnitude compare with 74x85-style
// cascade resolution.
//   a, b      : operands (unsigned, or two's complement when SIGNED_CMP=1)
//   casc_gt   : lower-significance stage reports A>B
//   casc_eq   : lower-significance stage reports A==B
//   casc_lt   : lower-significance stage reports A<B
//   result    : one-hot {gt, eq, lt}
module mag_cmp_core
    import mag_cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             casc_gt,
    input  logic             casc_eq,
    input  logic             casc_lt,
    output cmp_res_t         result
);

    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] b_x;
    logic             casc_eq_unused;

    // casc_eq only matters as the fallback, which is EQ anyway.
    assign casc_eq_unused = casc_eq;

    always_comb begin
        a_x = a;
        b_x = b;
        // Flipping the sign bit maps two's complement order onto unsigned order,
        // so a single unsigned (subtract-based) compare serves both modes.
        if (SIGNED_CMP) begin
            a_x[WIDTH-1] = ~a[WIDTH-1];
            b_x[WIDTH-1] = ~b[WIDTH-1];
        end

        if (a_x != b_x) begin
            result = pack_result(a_x > b_x, a_x < b_x);
        end else if (casc_gt) begin
            result = CMP_GT;
        end else if (casc_lt) begin
            result = CMP_LT;
        end else begin
            // casc_eq set, or all cascade inputs low: both resolve to equal.
            result = CMP_EQ;
        end
    end

endmodule

// File: rtl/magnitude_comparator.sv
// magnitude_comparator: registered magnitude compare stage, one cycle latency.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid          : qualifies a/b/cascade inputs this cycle
//   a, b              : operands
//   casc_gt/eq/lt     : cascade from a less-significant stage (tie 0/1/0 if unused)
//   out_valid         : registered in_valid
//   a_gt_b/eq_b/lt_b  : one-hot compare flags; hold their value while in_valid=0
module magnitude_comparator
    import mag_cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             casc_gt,
    input  logic             casc_eq,
    input  logic             casc_lt,
    output logic             out_valid,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    cmp_res_t res_d;
    cmp_res_t res_q;

    mag_cmp_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .a       (a),
        .b       (b),
        .casc_gt (casc_gt),
        .casc_eq (casc_eq),
        .casc_lt (casc_lt),
        .result  (res_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res_q     <= CMP_EQ;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign a_gt_b = res_q[2];
    assign a_eq_b = res_q[1];
    assign a_lt_b = res_q[0];

endmodule

// File: tb/tb_magnitude_comparator.sv
// tb_magnitude_comparator: drives an unsigned and a signed instance with the same
// stimulus and checks both against a behavioural model through a result queue.
module tb_magnitude_comparator;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         casc_gt;
    logic         casc_eq;
    logic         casc_lt;

    logic u_ov, u_gt, u_eq, u_lt;
    logic s_ov, s_gt, s_eq, s_lt;

    int checks = 0;
    int errors = 0;

    logic [2:0] q_u[$];
    logic [2:0] q_s[$];
    logic [2:0] held_u = 3'b010;
    logic [2:0] held_s = 3'b010;

    always #5 clk = ~clk;

    magnitude_comparator #(
        .WIDTH      (W),
        .SIGNED_CMP (1'b0)
    ) u_dut_u (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .casc_gt   (casc_gt),
        .casc_eq   (casc_eq),
        .casc_lt   (casc_lt),
        .out_valid (u_ov),
        .a_gt_b    (u_gt),
        .a_eq_b    (u_eq),
        .a_lt_b    (u_lt)
    );

    magnitude_comparator #(
        .WIDTH      (W),
        .SIGNED_CMP (1'b1)
    ) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .casc_gt   (casc_gt),
        .casc_eq   (casc_eq),
        .casc_lt   (casc_lt),
        .out_valid (s_ov),
        .a_gt_b    (s_gt),
        .a_eq_b    (s_eq),
        .a_lt_b    (s_lt)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic cg, input logic cl, input bit sgn);
        bit gt;
        bit lt;
        if (sgn) begin
            gt = $signed(x) > $signed(y);
            lt = $signed(x) < $signed(y);
        end else begin
            gt = x > y;
            lt = x < y;
        end
        if (gt) return 3'b100;
        if (lt) return 3'b001;
        if (cg) return 3'b100;
        if (cl) return 3'b001;
        return 3'b010;
    endfunction

    // One clock of stimulus, then check both instances just after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cg, input logic ce, input logic cl);
        logic exp_ov;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        casc_gt  = cg;
        casc_eq  = ce;
        casc_lt  = cl;
        if (!r && v) begin
            q_u.push_back(ref_cmp(x, y, cg, cl, 1'b0));
            q_s.push_back(ref_cmp(x, y, cg, cl, 1'b1));
        end
        @(posedge clk);
        #1;
        exp_ov = !r && v;
        if (r) begin
            held_u = 3'b010;
            held_s = 3'b010;
            q_u.delete();
            q_s.delete();
        end else if (v) begin
            if (q_u.size() > 0) held_u = q_u.pop_front();
            if (q_s.size() > 0) held_s = q_s.pop_front();
        end
        check_eq({tag, " u.valid"}, {7'd0, u_ov}, {7'd0, exp_ov});
        check_eq({tag, " u.flags"}, {5'd0, u_gt, u_eq, u_lt}, {5'd0, held_u});
        check_eq({tag, " u.onehot"}, {7'd0, $onehot({u_gt, u_eq, u_lt})}, 8'd1);
        check_eq({tag, " s.valid"}, {7'd0, s_ov}, {7'd0, exp_ov});
        check_eq({tag, " s.flags"}, {5'd0, s_gt, s_eq, s_lt}, {5'd0, held_s});
        check_eq({tag, " s.onehot"}, {7'd0, $onehot({s_gt, s_eq, s_lt})}, 8'd1);
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    initial begin
        vec_t dir[8];
        vec_t sgn[3];
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        casc_gt  = 1'b0;
        casc_eq  = 1'b1;
        casc_lt  = 1'b0;

        // Reset dominates a valid input.
        step("reset0", 1'b1, 1'b1, 4'd9, 4'd2, 1'b0, 1'b1, 1'b0);
        step("reset1", 1'b1, 1'b1, 4'd9, 4'd2, 1'b0, 1'b1, 1'b0);

        dir = '{'{4'd0, 4'd0}, '{4'd9, 4'd2}, '{4'd0, 4'd8}, '{4'd4, 4'd12},
                '{4'd12, 4'd11}, '{4'd6, 4'd8}, '{4'd5, 4'd2}, '{4'd5, 4'd15}};
        foreach (dir[i]) step("unsigned", 1'b0, 1'b1, dir[i].x, dir[i].y, 1'b0, 1'b1, 1'b0);

        // Flags hold while in_valid is low.
        step("hold_load", 1'b0, 1'b1, 4'd12, 4'd11, 1'b0, 1'b1, 1'b0);
        step("hold0", 1'b0, 1'b0, 4'd1, 4'd14, 1'b0, 1'b1, 1'b0);
        step("hold1", 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
        step("hold2", 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);

        step("casc_gt", 1'b0, 1'b1, 4'd7, 4'd7, 1'b1, 1'b0, 1'b0);
        step("casc_lt", 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1);
        step("casc_eq", 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
        step("casc_none", 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        step("casc_all", 1'b0, 1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1);
        step("casc_ignored", 1'b0, 1'b1, 4'd8, 4'd7, 1'b0, 1'b0, 1'b1);

        sgn = '{'{4'b1000, 4'b0000}, '{4'b1111, 4'b1110}, '{4'b0111, 4'b1000}};
        foreach (sgn[i]) step("signed", 1'b0, 1'b1, sgn[i].x, sgn[i].y, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            ra = W'($urandom());
            rb = ($urandom_range(3) == 0) ? ra : W'($urandom());
            step("random", ($urandom_range(99) == 0), 1'($urandom()), ra, rb,
                 1'($urandom()), 1'($urandom()), 1'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
